// File: rtl/fir_coeff_bank.sv
`default_nettype none
// ============================================================================
// fir_coeff_bank : shadow/active FIR coefficient bank with 4-phase strobe handshakes
// Optional FIR_COEFF_READBACK_EN enables tap readback. Rev 1.0
// ============================================================================
module fir_coeff_bank #(
  parameter int NTAPS   = 16,
  parameter int COEFF_W = 18,
  parameter int ADDR_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        addr_i,
  input  logic [31:0]              wdata_i,
  input  logic                     wr_strobe_i,
  output logic                     wr_ack_o,
  input  logic                     rd_strobe_i,
  output logic                     rd_ack_o,
  output logic [31:0]              rdata_o,
  input  logic                     frame_start_i,
  output logic [NTAPS*COEFF_W-1:0] coeff_flat_o,
  output logic                     coeff_update_o,
  output logic                     commit_pending_o
);

  localparam int IDX_W = ADDR_W - 2;
  localparam logic [IDX_W-1:0] CTRL_IDX  = IDX_W'(63);
  localparam logic [IDX_W-1:0] NTAPS_IDX = IDX_W'(62);

  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} hs_state_t;

  hs_state_t wr_state, wr_state_nxt, rd_state, rd_state_nxt;
  logic [2:0] wr_sync, rd_sync;
  logic wr_edge, rd_edge, wr_do, rd_do;
  logic rd_defer, rd_defer_nxt;
  logic pending;
  logic [IDX_W-1:0] idx;
  logic [31:0] rd_value;
  logic [COEFF_W-1:0] shadow [NTAPS];
  logic [COEFF_W-1:0] active [NTAPS];
  logic unused_bits;

  assign idx         = addr_i[ADDR_W-1:2];
  assign unused_bits = ^{wdata_i[31:COEFF_W], addr_i[1:0]};

  // bit 0 is q1, bit 2 is q3
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_sync <= '0;
      rd_sync <= '0;
    end else begin
      wr_sync <= {wr_sync[1:0], wr_strobe_i};
      rd_sync <= {rd_sync[1:0], rd_strobe_i};
    end
  end

  assign wr_edge = wr_sync[1] & ~wr_sync[2];
  assign rd_edge = rd_sync[1] & ~rd_sync[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state <= IDLE;
      rd_state <= IDLE;
      rd_defer <= 1'b0;
    end else begin
      wr_state <= wr_state_nxt;
      rd_state <= rd_state_nxt;
      rd_defer <= rd_defer_nxt;
    end
  end

  always_comb begin
    wr_state_nxt = wr_state;
    wr_do        = 1'b0;
    case (wr_state)
      IDLE: if (wr_edge) begin
        wr_do        = 1'b1;
        wr_state_nxt = ACK;
      end
      ACK:     if (!wr_sync[1]) wr_state_nxt = IDLE;
      default: wr_state_nxt = IDLE;
    endcase
  end

  // A read colliding with a write waits one cycle so it observes the new value
  always_comb begin
    rd_state_nxt = rd_state;
    rd_do        = 1'b0;
    rd_defer_nxt = 1'b0;
    case (rd_state)
      IDLE: if (rd_edge || rd_defer) begin
        if (wr_do) begin
          rd_defer_nxt = 1'b1;
        end else begin
          rd_do        = 1'b1;
          rd_state_nxt = ACK;
        end
      end
      ACK:     if (!rd_sync[1]) rd_state_nxt = IDLE;
      default: rd_state_nxt = IDLE;
    endcase
  end

  assign wr_ack_o = (wr_state == ACK);
  assign rd_ack_o = (rd_state == ACK);

  always_comb begin
    rd_value = '0;
`ifdef FIR_COEFF_READBACK_EN
    for (int k = 0; k < NTAPS; k++) begin
      if (idx == IDX_W'(k)) rd_value = {{(32-COEFF_W){shadow[k][COEFF_W-1]}}, shadow[k]};
    end
`endif
    if (idx == CTRL_IDX) begin
      rd_value = {31'b0, pending};
    end else if (idx == NTAPS_IDX) begin
      rd_value = 32'(NTAPS);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_o <= '0;
    end else if (rd_do) begin
      rdata_o <= rd_value;
    end
  end

  // Commit copies the pre-write shadow; a same-cycle commit write re-arms pending
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NTAPS; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
      pending        <= 1'b0;
      coeff_update_o <= 1'b0;
    end else begin
      coeff_update_o <= frame_start_i & pending;
      if (frame_start_i && pending) begin
        for (int k = 0; k < NTAPS; k++) active[k] <= shadow[k];
        pending <= 1'b0;
      end
      if (wr_do) begin
        for (int k = 0; k < NTAPS; k++) begin
          if (idx == IDX_W'(k)) shadow[k] <= wdata_i[COEFF_W-1:0];
        end
        if (idx == CTRL_IDX && wdata_i[0]) pending <= 1'b1;
      end
    end
  end

  assign commit_pending_o = pending;

  for (genvar k = 0; k < NTAPS; k++) begin : g_flat
    assign coeff_flat_o[k*COEFF_W +: COEFF_W] = active[k];
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_coeff_bank.sv
`default_nettype none
// tb_fir_coeff_bank : directed + randomized handshakes checked every cycle
// against a history-based behavioural model of the coefficient bank.
module tb_fir_coeff_bank;
  localparam int NTAPS   = 16;
  localparam int COEFF_W = 18;
  localparam int ADDR_W  = 8;
  localparam int FW      = NTAPS*COEFF_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [ADDR_W-1:0] addr = '0;
  logic [31:0] wdata = '0;
  logic wr_strobe = 1'b0, rd_strobe = 1'b0;
  logic frame_dir = 1'b0, frame_rnd = 1'b0, rand_frame = 1'b0;
  logic frame_start;
  logic wr_ack, rd_ack, coeff_update, commit_pending;
  logic [31:0] rdata;
  logic [FW-1:0] coeff_flat;

  assign frame_start = frame_dir | frame_rnd;

  fir_coeff_bank #(.NTAPS(NTAPS), .COEFF_W(COEFF_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .addr_i(addr), .wdata_i(wdata),
    .wr_strobe_i(wr_strobe), .wr_ack_o(wr_ack),
    .rd_strobe_i(rd_strobe), .rd_ack_o(rd_ack), .rdata_o(rdata),
    .frame_start_i(frame_start), .coeff_flat_o(coeff_flat),
    .coeff_update_o(coeff_update), .commit_pending_o(commit_pending)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  // Strobe histories (bit0 = level seen at the latest edge). An ack follows its
  // strobe two samples back; an action happens when that delayed level rises.
  logic [3:0] wh, rh;
  logic [COEFF_W-1:0] sh_m [NTAPS];
  logic [COEFF_W-1:0] ac_m [NTAPS];
  logic pend_m = 1'b0, upd_m = 1'b0, wack_m = 1'b0, rack_m = 1'b0, defer_m = 1'b0;
  logic [31:0] rdata_m = '0;
  logic model_started = 1'b0;

  function automatic logic [31:0] model_read(input int i);
    if (i == 63) return {31'b0, pend_m};
    if (i == 62) return NTAPS;
`ifdef FIR_COEFF_READBACK_EN
    if (i < NTAPS) return {{(32-COEFF_W){sh_m[i][COEFF_W-1]}}, sh_m[i]};
`endif
    return 32'h0;
  endfunction

  initial begin
    logic w_act, r_rise, r_act, new_defer;
    int i;
    forever begin
      @(posedge clk);
      model_started = 1'b1;
      i = int'(addr[ADDR_W-1:2]);
      if (rst) begin
        wh = '0; rh = '0; defer_m = 0; pend_m = 0; upd_m = 0;
        wack_m = 0; rack_m = 0; rdata_m = '0;
        for (int k = 0; k < NTAPS; k++) begin sh_m[k] = '0; ac_m[k] = '0; end
      end else begin
        wh = {wh[2:0], wr_strobe};
        rh = {rh[2:0], rd_strobe};
        w_act     = wh[2] & ~wh[3];
        r_rise    = rh[2] & ~rh[3];
        new_defer = r_rise & w_act;
        r_act     = defer_m | (r_rise & ~w_act);
        if (r_act) rdata_m = model_read(i);
        upd_m = frame_start & pend_m;
        if (upd_m) begin
          for (int k = 0; k < NTAPS; k++) ac_m[k] = sh_m[k];
          pend_m = 1'b0;
        end
        if (w_act) begin
          if (i < NTAPS) sh_m[i] = wdata[COEFF_W-1:0];
          if (i == 63 && wdata[0]) pend_m = 1'b1;
        end
        defer_m = new_defer;
        wack_m  = wh[2];
        rack_m  = rh[2] & ~new_defer;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    logic [FW-1:0] flat_m;
    wait (model_started);
    forever begin
      @(negedge clk);
      for (int k = 0; k < NTAPS; k++) flat_m[k*COEFF_W +: COEFF_W] = ac_m[k];
      check("wr_ack", FW'(wr_ack), FW'(wack_m));
      check("rd_ack", FW'(rd_ack), FW'(rack_m));
      check("rdata", FW'(rdata), FW'(rdata_m));
      check("coeff_update", FW'(coeff_update), FW'(upd_m));
      check("commit_pending", FW'(commit_pending), FW'(pend_m));
      check("coeff_flat", coeff_flat, flat_m);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      frame_rnd = rand_frame ? ($urandom_range(0, 6) == 0) : 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_sig(input bit rd, input logic val, output int lat);
    lat = -1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if ((rd ? rd_ack : wr_ack) === val) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic xfer(input bit do_wr, input bit do_rd, input logic [ADDR_W-1:0] a, input logic [31:0] d);
    int lat;
    addr = a; wdata = d;
    wr_strobe = do_wr; rd_strobe = do_rd;
    if (do_rd) begin wait_sig(1'b1, 1'b1, lat); check("rd_ack_rise_timeout", FW'(lat >= 0), FW'(1)); end
    if (do_wr) begin wait_sig(1'b0, 1'b1, lat); check("wr_ack_rise_timeout", FW'(lat >= 0), FW'(1)); end
    wr_strobe = 1'b0; rd_strobe = 1'b0;
    if (do_rd) begin wait_sig(1'b1, 1'b0, lat); check("rd_ack_fall_timeout", FW'(lat >= 0), FW'(1)); end
    if (do_wr) begin wait_sig(1'b0, 1'b0, lat); check("wr_ack_fall_timeout", FW'(lat >= 0), FW'(1)); end
  endtask

  task automatic pulse_frame();
    frame_dir = 1'b1;
    @(negedge clk);
    frame_dir = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    logic [31:0] exp_rd;
    logic [5:0] ridx;
    repeat (3) @(negedge clk);
    check("reset_flat", coeff_flat, '0);
    check("reset_rdata", FW'(rdata), FW'(0));
    rst = 1'b0;
    @(negedge clk);

    // tap 3 write with latency measurement
    addr = 8'h0C; wdata = 32'h0001_FFFE; wr_strobe = 1'b1;
    wait_sig(1'b0, 1'b1, lat);
    check("wr_rise_latency", FW'(lat), FW'(3));
    check("tap3_not_yet_active", FW'(coeff_flat[3*COEFF_W +: COEFF_W]), FW'(0));
    check("model_shadow3", FW'(sh_m[3]), FW'(18'h1FFFE));
    wr_strobe = 1'b0;
    wait_sig(1'b0, 1'b0, lat);
    check("wr_fall_latency", FW'(lat), FW'(3));

    // commit at frame boundary
    xfer(1'b1, 1'b0, 8'hFC, 32'h1);
    check("pending_set", FW'(commit_pending), FW'(1));
    pulse_frame();
    check("update_pulse", FW'(coeff_update), FW'(1));
    check("tap3_committed", FW'(coeff_flat[3*COEFF_W +: COEFF_W]), FW'(18'h1FFFE));
    check("pending_cleared", FW'(commit_pending), FW'(0));
    @(negedge clk);
    check("update_one_cycle", FW'(coeff_update), FW'(0));

    // commit write coinciding with frame_start: deferred to the next frame
    addr = 8'hFC; wdata = 32'h1; wr_strobe = 1'b1;
    repeat (2) @(negedge clk);
    frame_dir = 1'b1;
    @(negedge clk);
    frame_dir = 1'b0;
    check("same_cycle_ack", FW'(wr_ack), FW'(1));
    check("same_cycle_no_update", FW'(coeff_update), FW'(0));
    check("same_cycle_pending", FW'(commit_pending), FW'(1));
    wr_strobe = 1'b0;
    wait_sig(1'b0, 1'b0, lat);
    pulse_frame();
    check("next_frame_update", FW'(coeff_update), FW'(1));

    // simultaneous write and read on tap 2
    addr = 8'h08; wdata = 32'h0000_0123; wr_strobe = 1'b1; rd_strobe = 1'b1;
    wait_sig(1'b1, 1'b1, lat);
    check("rd_deferred_latency", FW'(lat), FW'(4));
`ifdef FIR_COEFF_READBACK_EN
    exp_rd = 32'h0000_0123;
`else
    exp_rd = 32'h0;
`endif
    check("rdata_after_collision", FW'(rdata), FW'(exp_rd));
    wr_strobe = 1'b0; rd_strobe = 1'b0;
    wait_sig(1'b1, 1'b0, lat);
    wait_sig(1'b0, 1'b0, lat);

    // unused index write, NTAPS register read
    xfer(1'b1, 1'b0, 8'h80, 32'hFFFF_FFFF);
    check("unused_no_pending", FW'(commit_pending), FW'(0));
    xfer(1'b0, 1'b1, 8'hF8, 32'h0);
    check("ntaps_read", FW'(rdata), FW'(16));

    // reset in the middle of a write handshake
    addr = 8'h14; wdata = 32'h3_0005; wr_strobe = 1'b1;
    wait_sig(1'b0, 1'b1, lat);
    rst = 1'b1;
    @(negedge clk);
    check("ack_cleared_by_reset", FW'(wr_ack), FW'(0));
    check("flat_cleared_by_reset", coeff_flat, '0);
    rst = 1'b0;
    wait_sig(1'b0, 1'b1, lat);
    check("ack_after_reset_latency", FW'(lat), FW'(3));
    wr_strobe = 1'b0;
    wait_sig(1'b0, 1'b0, lat);
    xfer(1'b0, 1'b1, 8'h14, 32'h0);
`ifdef FIR_COEFF_READBACK_EN
    exp_rd = 32'hFFFF_0005;
`else
    exp_rd = 32'h0;
`endif
    check("tap5_rewritten_sext", FW'(rdata), FW'(exp_rd));

    // randomized traffic with background frame pulses
    rand_frame = 1'b1;
    for (int t = 0; t < 200; t++) begin
      int kind, sel;
      kind = $urandom_range(0, 2);
      sel  = $urandom_range(0, 9);
      if (sel < 6)       ridx = 6'($urandom_range(0, NTAPS-1));
      else if (sel == 6) ridx = 6'h3F;
      else if (sel == 7) ridx = 6'h3E;
      else               ridx = 6'($urandom_range(NTAPS, 61));
      xfer(kind != 1, kind != 0, {ridx, 2'($urandom_range(0, 3))}, $urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    rand_frame = 1'b0;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fir_coeff_bank.md
Name: fir_coeff_bank

Overview:
- Pixel-clock-domain consumer of the FIR AXI-Lite front end's coefficient write strobe and read strobe.
- Takes each handshake request, synchronizes it and writes the coefficient into a shadow register bank (or reads it back), then returns a level acknowledge.
- Shadow contents move to the active bank only at a frame boundary after a commit request. The FIR datapath never sees a half-updated kernel.

Parameters:
- NTAPS, 16, number of coefficient taps (max 62).
- COEFF_W, 18, stored coefficient width; signed, taken from wdata[COEFF_W-1:0].
- ADDR_W, 8, byte address width; word index = addr_i[ADDR_W-1:2].

Ports:
- clk  in  1  pixel clock; the only clock.
- rst  in  1  synchronous reset, active-high.
- addr_i  in  ADDR_W  byte address from the AXI front end; stable while a strobe is high.
- wdata_i  in  32  write data; stable while wr_strobe_i is high.
- wr_strobe_i  in  1  write request level, asynchronous to clk.
- wr_ack_o  out  1  write acknowledge level.
- rd_strobe_i  in  1  read request level, asynchronous to clk.
- rd_ack_o  out  1  read acknowledge level.
- rdata_o  out  32  read data; valid and stable while rd_ack_o=1.
- frame_start_i  in  1  one-cycle pulse at start of frame, clk domain.
- coeff_flat_o  out  NTAPS*COEFF_W  active coefficients; tap k at bits [k*COEFF_W +: COEFF_W].
- coeff_update_o  out  1  one-cycle pulse when the active bank was reloaded.
- commit_pending_o  out  1  a commit is waiting for frame_start_i.

Behaviour:
- Reset values: all outputs 0, shadow bank 0, active bank 0, pending 0, synchronizer flops 0.
- Each strobe passes through a 3-flop chain (q1, q2, q3). The request edge is q2 & ~q3.
- Four-phase handshake, write and read each with an independent 2-state FSM: IDLE, ACK.
  - IDLE -> ACK on the request edge. The action happens on the edge cycle and the ack rises on the next cycle.
  - ACK -> IDLE when q2 is low; the ack falls on the following cycle.
  - Latency: strobe rise to ack rise is 3 clk cycles; strobe fall to ack fall is 3 clk cycles.
- Address map by word index:
  - 0..NTAPS-1: shadow tap.
  - 0x3F: control. A write with wdata[0]=1 sets pending; a read returns {31'b0, pending}.
  - 0x3E: read-only, returns NTAPS.
  - Other indices: writes ignored but still acked; reads return 0.
- Tap read returns the shadow value sign-extended to 32 bits.
- rdata_o is registered on the read action and held until the next read action.
- Commit: on frame_start_i with pending=1:
  - active <= shadow and pending <= 0 on that edge.
  - coeff_update_o is high on the next cycle.
  - frame_start_i with pending=0 does nothing.
- Simultaneous events:
  - Commit write and frame_start_i in the same cycle: no commit this frame (old pending=0 is evaluated); commit happens at the next frame_start_i.
  - Tap write and commit in the same cycle: active takes the pre-write shadow value.
  - Write and read edges in the same cycle: the write is performed; the read action is deferred one cycle and returns the new value. rd_ack_o latency becomes 4.
- Reset mid-handshake: acks drop and the FSMs return to IDLE. A strobe still high after reset produces a fresh edge and the request is serviced again (writes are idempotent).
- A new edge while in ACK cannot occur, because the strobe must fall first. No queueing is required.
- coeff_flat_o changes only on a commit edge.

Optional Feature:
- Macro FIR_COEFF_READBACK_EN.
- Defined: tap reads return the shadow value as above.
- Not defined:
  - Tap reads return 0 and the read bank mux is not built.
  - The control and NTAPS registers still read normally.
  - Read handshake timing is unchanged.

Test Plan:
- Reset, then write tap 3 (addr 0x0C, wdata 0x0001_FFFE) -> wr_ack_o rises 3 cycles after strobe; coeff_flat_o tap 3 still 0; after strobe drop, ack falls 3 cycles later.
- Write 0x3F with wdata=1 -> commit_pending_o=1. Pulse frame_start_i -> tap 3 = 18'h1FFFE in coeff_flat_o; coeff_update_o high exactly one cycle; pending=0.
- Commit write and frame_start_i in the same cycle -> no update. Next frame_start_i -> update pulse.
- Write and read strobes rise together on addr 0x08 with wdata 0x0000_0123:
  - with FIR_COEFF_READBACK_EN: rd_ack_o rises at cycle 4 and rdata_o=0x0000_0123;
  - without it: rdata_o=0.
- Write to addr 0x80 (index 0x20, unused) -> acked, no register changes. Read 0xF8 -> rdata_o=16.
- Assert rst while wr_ack_o=1 with strobe held high -> ack clears. After release, a second write occurs and the ack rises 3 cycles later.
